// File: rtl/ysyx_22040759_lsu.sv
// Load/store unit between the execute stage and the data memory.
// Handles one access at a time: it aligns the request to 8 bytes, places store
// data into its byte lanes, waits for the memory response, then extends load
// data for writeback. Misaligned or illegal accesses never reach memory.
module ysyx_22040759_lsu #(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_ren,
   input  logic          in_wen,
   input  logic [2:0]    in_func3,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_wdata,
   output logic          mem_req_valid,
   input  logic          mem_req_ready,
   output logic          mem_req_wen,
   output logic [AW-1:0] mem_req_addr,
   output logic [DW-1:0] mem_req_wdata,
   output logic [7:0]    mem_req_wmask,
   input  logic          mem_resp_valid,
   input  logic [DW-1:0] mem_resp_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_rdata,
   output logic          out_fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   logic [2:0]  off_r;
   logic [2:0]  func3_r;
   logic        store_r;

   logic        misalign_s;
   logic        illegal_s;
   logic        fault_s;
   logic [7:0]  wmask_s;
   logic [DW-1:0] wdata_s;

   // Byte-lane mask of an access of 1, 2, 4 or 8 bytes, starting at lane 0.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_bits(input logic [1:0] sz);
      case (sz)
         2'd0:    return 3'b000;
         2'd1:    return 3'b001;
         2'd2:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   // Keep only the bytes of store data that belong to the access size.
   function automatic logic [DW-1:0] trunc_data(input logic [1:0] sz,
                                                input logic [DW-1:0] d);
      case (sz)
         2'd0:    return {{(DW-8){1'b0}},  d[7:0]};
         2'd1:    return {{(DW-16){1'b0}}, d[15:0]};
         2'd2:    return {{(DW-32){1'b0}}, d[31:0]};
         default: return d;
      endcase
   endfunction

   // Shift the addressed field down to lane 0 and sign- or zero-extend it.
   function automatic logic [DW-1:0] load_extend(input logic [2:0] f3,
                                                 input logic [2:0] off,
                                                 input logic [DW-1:0] rdata);
      logic [DW-1:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  return {{(DW-8){sh[7]}},   sh[7:0]};
         3'b001:  return {{(DW-16){sh[15]}}, sh[15:0]};
         3'b010:  return {{(DW-32){sh[31]}}, sh[31:0]};
         3'b011:  return sh;
         3'b100:  return {{(DW-8){1'b0}},    sh[7:0]};
         3'b101:  return {{(DW-16){1'b0}},   sh[15:0]};
         3'b110:  return {{(DW-32){1'b0}},   sh[31:0]};
         default: return {DW{1'b0}};
      endcase
   endfunction

   // Decode fault conditions and build lane-shifted store fields from the raw inputs.
   always_comb begin
      misalign_s = |(in_addr[2:0] & align_bits(in_func3[1:0]));
      if (in_wen) begin
         illegal_s = in_func3[2];
         wmask_s   = size_mask(in_func3[1:0]) << in_addr[2:0];
         wdata_s   = trunc_data(in_func3[1:0], in_wdata) << {in_addr[2:0], 3'b000};
      end else begin
         illegal_s = (in_func3 == 3'b111);
         wmask_s   = 8'h00;
         wdata_s   = {DW{1'b0}};
      end
      fault_s = misalign_s | illegal_s;
   end

   // Access FSM with all handshake and data outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         off_r         <= 3'b000;
         func3_r       <= 3'b000;
         store_r       <= 1'b0;
         in_ready      <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_req_wen   <= 1'b0;
         mem_req_addr  <= {AW{1'b0}};
         mem_req_wdata <= {DW{1'b0}};
         mem_req_wmask <= 8'h00;
         out_valid     <= 1'b0;
         out_rdata     <= {DW{1'b0}};
         out_fault     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  in_ready  <= 1'b0;
                  off_r     <= in_addr[2:0];
                  func3_r   <= in_func3;
                  store_r   <= in_wen;
                  out_rdata <= {DW{1'b0}};
                  if (!in_wen && !in_ren) begin
                     out_fault <= 1'b0;
                     out_valid <= 1'b1;
                     state_r   <= DONE;
                  end else if (fault_s) begin
                     out_fault <= 1'b1;
                     out_valid <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     out_fault     <= 1'b0;
                     mem_req_valid <= 1'b1;
                     mem_req_wen   <= in_wen;
                     mem_req_addr  <= {in_addr[AW-1:3], 3'b000};
                     mem_req_wdata <= wdata_s;
                     mem_req_wmask <= wmask_s;
                     state_r       <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state_r       <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  out_rdata <= store_r ? {DW{1'b0}}
                                       : load_extend(func3_r, off_r, mem_resp_rdata);
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r       <= IDLE;
               in_ready      <= 1'b1;
               mem_req_valid <= 1'b0;
               out_valid     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040759_lsu.sv
// Directed testbench for ysyx_22040759_lsu with hand-computed expected values.
module tb_ysyx_22040759_lsu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_ren;
   logic        in_wen;
   logic [2:0]  in_func3;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wen;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_rdata;
   logic        out_fault;

   int vectors;
   int miscompares;

   ysyx_22040759_lsu #(.AW(64), .DW(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_ren         (in_ren),
      .in_wen         (in_wen),
      .in_func3       (in_func3),
      .in_addr        (in_addr),
      .in_wdata       (in_wdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_wen    (mem_req_wen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rdata      (out_rdata),
      .out_fault      (out_fault)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata);
      in_valid = 1'b1;
      in_ren   = ren;
      in_wen   = wen;
      in_func3 = f3;
      in_addr  = addr;
      in_wdata = wdata;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
      vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset mem_req_valid got %b exp 0", mem_req_valid); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      vectors++; if (out_fault !== 1'b0) begin miscompares++; $display("FAIL reset out_fault got %b exp 0", out_fault); end
      vectors++; if (out_rdata !== 64'h0) begin miscompares++; $display("FAIL reset out_rdata got %h exp 0", out_rdata); end
      vectors++; if ({mem_req_wmask, mem_req_wdata, mem_req_addr} !== 136'h0) begin miscompares++; $display("FAIL reset mem_req fields got %h %h %h exp 0", mem_req_wmask, mem_req_wdata, mem_req_addr); end
   endtask

   task automatic test_store_sh();
      mem_req_ready = 1'b1;
      present(1'b0, 1'b1, 3'b001, 64'h0000_0000_8000_0006, 64'h0000_0000_1234_ABCD);
      tick();
      in_valid = 1'b0;
      vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL sh mem_req_valid got %b exp 1", mem_req_valid); end
      vectors++; if (mem_req_wen !== 1'b1) begin miscompares++; $display("FAIL sh mem_req_wen got %b exp 1", mem_req_wen); end
      vectors++; if (mem_req_addr !== 64'h0000_0000_8000_0000) begin miscompares++; $display("FAIL sh mem_req_addr got %h exp 80000000", mem_req_addr); end
      vectors++; if (mem_req_wmask !== 8'hC0) begin miscompares++; $display("FAIL sh wmask got %h exp c0", mem_req_wmask); end
      vectors++; if (mem_req_wdata !== 64'hABCD_0000_0000_0000) begin miscompares++; $display("FAIL sh wdata got %h exp abcd000000000000", mem_req_wdata); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL sh in_ready busy got %b exp 0", in_ready); end
      tick();
      mem_req_ready = 1'b0;
      vectors++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL sh wait req/out got %b/%b exp 0/0", mem_req_valid, out_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      mem_resp_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sh out_valid T+3 got %b exp 1", out_valid); end
      vectors++; if (out_rdata !== 64'h0 || out_fault !== 1'b0) begin miscompares++; $display("FAIL sh result got %h/%b exp 0/0", out_rdata, out_fault); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL sh release out_valid/in_ready got %b/%b exp 0/1", out_valid, in_ready); end
   endtask

   task automatic run_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
      mem_req_ready = 1'b1;
      present(1'b1, 1'b0, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      in_valid = 1'b0;
      vectors++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b0) begin miscompares++; $display("FAIL %s req valid/wen got %b/%b exp 1/0", name, mem_req_valid, mem_req_wen); end
      vectors++; if (mem_req_addr !== {addr[63:3], 3'b000}) begin miscompares++; $display("FAIL %s req addr got %h exp %h", name, mem_req_addr, {addr[63:3], 3'b000}); end
      vectors++; if (mem_req_wmask !== 8'h00 || mem_req_wdata !== 64'h0) begin miscompares++; $display("FAIL %s load wmask/wdata got %h/%h exp 0/0", name, mem_req_wmask, mem_req_wdata); end
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 64'h0;
      vectors++; if (out_valid !== 1'b1 || out_fault !== 1'b0) begin miscompares++; $display("FAIL %s out_valid/fault got %b/%b exp 1/0", name, out_valid, out_fault); end
      vectors++; if (out_rdata !== exp) begin miscompares++; $display("FAIL %s out_rdata got %h exp %h", name, out_rdata, exp); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_load_byte();
      run_load("lb",  3'b000, 64'h0000_0000_8000_0003, 64'h0000_0000_F100_0000, 64'hFFFF_FFFF_FFFF_FFF1);
      run_load("lbu", 3'b100, 64'h0000_0000_8000_0003, 64'h0000_0000_F100_0000, 64'h0000_0000_0000_00F1);
      run_load("lhu", 3'b101, 64'h0000_0000_8000_0006, 64'h9A8B_0000_0000_0000, 64'h0000_0000_0000_9A8B);
   endtask

   task automatic test_ld();
      run_load("ld", 3'b011, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
   endtask

   task automatic test_fault(input string name, input logic ren, input logic wen, input logic [2:0] f3,
                             input logic [63:0] addr, input logic exp_fault);
      mem_req_ready = 1'b1;
      present(ren, wen, f3, addr, 64'h5555_5555_5555_5555);
      tick();
      in_valid = 1'b0;
      vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL %s mem_req_valid got %b exp 0", name, mem_req_valid); end
      vectors++; if (out_valid !== 1'b1 || out_fault !== exp_fault) begin miscompares++; $display("FAIL %s out_valid/fault got %b/%b exp 1/%b", name, out_valid, out_fault, exp_fault); end
      vectors++; if (out_rdata !== 64'h0) begin miscompares++; $display("FAIL %s out_rdata got %h exp 0", name, out_rdata); end
      out_ready = 1'b1;
      tick();
      out_ready     = 1'b0;
      mem_req_ready = 1'b0;
      vectors++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL %s after in_ready/req got %b/%b exp 1/0", name, in_ready, mem_req_valid); end
   endtask

   task automatic test_backpressure();
      mem_req_ready = 1'b0;
      present(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0);
      tick();
      in_valid = 1'b0;
      in_addr  = 64'h0000_0000_0000_0F00;
      in_func3 = 3'b011;
      in_wen   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0000_0000_8000_0000 || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp req hold cycle %0d got v%b a%h w%b m%h r%b exp v1 a80000000 w0 m00 r0", i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, in_ready); end
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'h8765_4321_0000_0000;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 64'h0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (out_valid !== 1'b1 || out_rdata !== 64'hFFFF_FFFF_8765_4321 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp out hold cycle %0d got v%b d%h r%b exp v1 dffffffff87654321 r0", i, out_valid, out_rdata, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      in_wen    = 1'b0;
      tick();
      out_ready = 1'b0;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp release in_ready/out_valid got %b/%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_reset_in_wait();
      mem_req_ready = 1'b1;
      present(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0010, 64'h0);
      tick();
      in_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'h1111_2222_3333_4444;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait after reset got r%b o%b q%b exp r1 o0 q0", in_ready, out_valid, mem_req_valid); end
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 64'h0;
      tick();
      vectors++; if (out_valid !== 1'b0 || out_rdata !== 64'h0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rstwait late resp got o%b d%h r%b exp o0 d0 r1", out_valid, out_rdata, in_ready); end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b1;
      in_valid       = 1'b0;
      in_ren         = 1'b0;
      in_wen         = 1'b0;
      in_func3       = 3'b000;
      in_addr        = 64'h0;
      in_wdata       = 64'h0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 64'h0;
      out_ready      = 1'b0;

      test_reset();
      test_store_sh();
      test_load_byte();
      test_fault("misaligned_lw", 1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0002, 1'b1);
      test_fault("illegal_load",  1'b1, 1'b0, 3'b111, 64'h0000_0000_8000_0000, 1'b1);
      test_fault("illegal_store", 1'b0, 1'b1, 3'b100, 64'h0000_0000_8000_0000, 1'b1);
      test_fault("no_op",         1'b0, 1'b0, 3'b010, 64'h0000_0000_8000_0002, 1'b0);
      test_backpressure();
      test_reset_in_wait();
      test_ld();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
